// File: rtl/gbt_rx_frameclk_phalgnr_pkg.sv
// gbt_rx_frameclk_phalgnr_pkg: FSM state type, default constants and counter sizing for the phase-aligner controller
package gbt_rx_frameclk_phalgnr_pkg;
    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_LOCK,
        S_CHECK,
        S_PULSE,
        S_WAIT_DONE_LO,
        S_WAIT_DONE_HI,
        S_SETTLE,
        S_DONE,
        S_FAIL
    } state_e;
    localparam int         DEF_MAX_STEPS = 144;
    localparam logic [4:0] DEF_CNTSEL    = 5'd0;
    localparam logic       DEF_UPDN_DIR  = 1'b1;
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction
endpackage

// File: rtl/gbt_rx_frameclk_phalgnr_ctrl_sync2.sv
// gbt_phalgnr_sync2: two-flop synchroniser for the asynchronous alignment flag
module gbt_phalgnr_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    // shift the asynchronous level through two flops before use
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], d_i};
    assign q_o = sync_q[1];
endmodule

// File: rtl/gbt_rx_frameclk_phalgnr_ctrl.sv
// gbt_rx_frameclk_phalgnr_ctrl: steps the PLL C0 phase via DPS until the frame header is aligned; GBT_PHALGNR_DONE_TIMEOUT_EN adds a phase_done watchdog
module gbt_rx_frameclk_phalgnr_ctrl
    import gbt_rx_frameclk_phalgnr_pkg::*;
#(
    parameter int         MAX_STEPS     = DEF_MAX_STEPS,
    parameter int         SETTLE_CYCLES = 16,
    parameter int         PHEN_CYCLES   = 2,
    parameter int         DONE_TIMEOUT  = 255,
    parameter logic [4:0] CNTSEL        = DEF_CNTSEL,
    parameter logic       UPDN_DIR      = DEF_UPDN_DIR
) (
    input  logic       scanclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       locked,
    input  logic       phase_done,
    input  logic       aligned,
    output logic       phase_en,
    output logic       updn,
    output logic [4:0] cntsel,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] step_cnt
);
    localparam int            CW      = cnt_width(SETTLE_CYCLES, PHEN_CYCLES, DONE_TIMEOUT);
    localparam logic [CW-1:0] PH_LAST = CW'(PHEN_CYCLES - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]    MAX_Q   = 8'(MAX_STEPS);
`ifdef GBT_PHALGNR_DONE_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(DONE_TIMEOUT - 1);
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [7:0]    step_cnt_q, step_d;
    logic          start_q, aligned_s, lock_lost, busy_d;
    logic          phase_en_q, updn_q, busy_q, done_q, error_q;
    logic [4:0]    cntsel_q;

    gbt_phalgnr_sync2 u_sync (
        .clk  (scanclk),
        .rst_n(rst_n),
        .d_i  (aligned),
        .q_o  (aligned_s)
    );

    assign lock_lost = !locked && (state_q inside {S_CHECK, S_PULSE, S_WAIT_DONE_LO, S_WAIT_DONE_HI, S_SETTLE});
    assign busy_d    = !(state_d inside {S_IDLE, S_DONE, S_FAIL});

    // next state and step count; a lock drop overrides everything and restarts the run from zero
    always_comb begin
        state_d = state_q;
        step_d  = step_cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL:
                if (start_q) begin
                    state_d = S_WAIT_LOCK;
                    step_d  = '0;
                end
            S_WAIT_LOCK:
                if (locked) state_d = S_CHECK;
            S_CHECK:
                state_d = aligned_s ? S_DONE : (step_cnt_q == MAX_Q) ? S_FAIL : S_PULSE;
            S_PULSE:
                if (cnt_q == PH_LAST) state_d = S_WAIT_DONE_LO;
            S_WAIT_DONE_LO:
                if (!phase_done) state_d = S_WAIT_DONE_HI;
`ifdef GBT_PHALGNR_DONE_TIMEOUT_EN
                else if (cnt_q == TO_LAST) state_d = S_FAIL;
`endif
            S_WAIT_DONE_HI:
                if (phase_done) begin
                    state_d = S_SETTLE;
                    step_d  = (step_cnt_q == MAX_Q) ? step_cnt_q : step_cnt_q + 8'd1;
                end
`ifdef GBT_PHALGNR_DONE_TIMEOUT_EN
                else if (cnt_q == TO_LAST) state_d = S_FAIL;
`endif
            S_SETTLE:
                if (cnt_q == ST_LAST) state_d = S_CHECK;
            default:
                state_d = S_IDLE;
        endcase
        if (lock_lost) begin
            state_d = S_WAIT_LOCK;
            step_d  = '0;
        end
    end

    // state, per-state dwell counter and outputs registered from the next state
    always_ff @(posedge scanclk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            step_cnt_q <= '0;
            start_q    <= 1'b0;
            phase_en_q <= 1'b0;
            updn_q     <= 1'b0;
            cntsel_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
            step_cnt_q <= step_d;
            start_q    <= start;
            phase_en_q <= state_d == S_PULSE;
            updn_q     <= busy_d && UPDN_DIR;
            cntsel_q   <= busy_d ? CNTSEL : '0;
            busy_q     <= busy_d;
            done_q     <= state_d == S_DONE;
            error_q    <= state_d == S_FAIL;
        end

    assign phase_en = phase_en_q;
    assign updn     = updn_q;
    assign cntsel   = cntsel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign step_cnt = step_cnt_q;
endmodule

// File: doc/gbt_rx_frameclk_phalgnr_ctrl.md
# gbt_rx_frameclk_phalgnr_ctrl

Dynamic-phase-shift controller for the GBT RX frame-clock phase aligner PLL. It runs in the PLL `scanclk` domain and drives the PLL's `phase_en`/`updn`/`cntsel` inputs, handshaking on `phase_done`. It steps the 40 MHz frame clock (C0) one VCO/8 increment at a time until the upstream header-alignment detector reports `aligned`, then reports the step count. It sits directly upstream of the PLL's DPS port.

## Interface
Parameters:
- `MAX_STEPS`, 144: step budget. One 25 ns frame period is 18 VCO periods × 8 steps.
- `SETTLE_CYCLES`, 16: `scanclk` cycles waited after each completed step before sampling `aligned`.
- `PHEN_CYCLES`, 2: width of the `phase_en` pulse, in cycles (≥1).
- `DONE_TIMEOUT`, 255: maximum cycles allowed per `phase_done` wait phase. Used only with the macro defined.
- `CNTSEL`, 5'd0: counter select driven to the PLL (C0).
- `UPDN_DIR`, 1'b1: step direction (1 = up).

Ports:
- `scanclk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse that begins an alignment run. Ignored while `busy`.
- `locked` in 1: PLL lock. Synchronous to `scanclk`.
- `phase_done` in 1: PLL DPS completion. Synchronous to `scanclk`.
- `aligned` in 1: asynchronous alignment flag. Double-flop synchronised internally.
- `phase_en` out 1: PLL step request.
- `updn` out 1: step direction to PLL.
- `cntsel` out 5: counter select to PLL.
- `busy` out 1: a run is in progress.
- `done` out 1: run succeeded. Sticky until the next `start`.
- `error` out 1: run failed (budget exhausted or timeout). Sticky until the next `start`.
- `step_cnt` out 8: number of completed steps in the current or last run.

## Operation
- FSM states: IDLE, WAIT_LOCK, CHECK, PULSE, WAIT_DONE_LO, WAIT_DONE_HI, SETTLE, DONE, FAIL.
- IDLE: on `start`, clear `done`/`error`/`step_cnt` and go to WAIT_LOCK.
- DONE or FAIL: on `start`, same as IDLE. Otherwise hold.
- WAIT_LOCK: when `locked`=1, go to CHECK.
- CHECK: evaluated in one cycle, in this order:
  - synchronised `aligned`=1 → DONE;
  - else `step_cnt`==MAX_STEPS → FAIL;
  - else → PULSE.
- PULSE: `phase_en`=1 for exactly PHEN_CYCLES cycles, then → WAIT_DONE_LO.
- WAIT_DONE_LO: waits for `phase_done`=0, then → WAIT_DONE_HI.
- WAIT_DONE_HI: waits for `phase_done`=1, then increments `step_cnt` and goes to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then → CHECK.
- `busy` = 1 in every state except IDLE, DONE and FAIL.
- `updn`=UPDN_DIR and `cntsel`=CNTSEL while `busy`; both are 0 otherwise. Both are stable before, during and after each `phase_en` pulse.
- `locked` falling in any busy state other than WAIT_LOCK:
  - `phase_en` is deasserted immediately (registered, next cycle);
  - `step_cnt` is cleared;
  - the FSM goes to WAIT_LOCK.
  - The run restarts from zero; the PLL relocks at its reset phase.
- `step_cnt` saturates at MAX_STEPS and never wraps.
- `start` and a `locked` drop in the same cycle from IDLE: go to WAIT_LOCK as normal.

## Timing
- All outputs are registered.
- Reset values: `phase_en`=0, `updn`=0, `cntsel`=0, `busy`=0, `done`=0, `error`=0, `step_cnt`=0. FSM resets to IDLE.
- `start` sampled at edge N: `busy`=1 after edge N+1.
- If already aligned and locked at start, `done`=1 at N+1 + 2 (WAIT_LOCK, CHECK).
- `aligned` synchroniser latency: 2 cycles. SETTLE_CYCLES ≥ 2 is mandatory so post-step alignment is observed.
- Per-step minimum: 1 (CHECK) + PHEN_CYCLES + 1 + 1 + SETTLE_CYCLES cycles.
- `done` and `error` are never high together.

## Configuration
- `GBT_PHALGNR_DONE_TIMEOUT_EN` defined:
  - a watchdog counts cycles in each of WAIT_DONE_LO and WAIT_DONE_HI separately;
  - on reaching DONE_TIMEOUT, the FSM goes to FAIL with `error`=1 and `step_cnt` unchanged.
- Undefined: both states wait indefinitely, and the watchdog logic is absent.

## Structure
- Shared package `gbt_rx_frameclk_phalgnr_pkg` holds:
  - the FSM state enum;
  - default constants: 144 steps, C0 select 5'd0, step direction.
- Sub-module `gbt_phalgnr_sync2`: 2-flop synchroniser for `aligned`, reset to 0 by `rst_n`.
- Everything else is a single FSM with counters in the top module.

## Test plan
- Already aligned: `locked`=1, `aligned`=1, pulse `start` → `done`=1 three cycles later, `step_cnt`=0, `phase_en` never asserted.
- Aligned after steps: PLL model drops `phase_done` 3 cycles after `phase_en` and raises it 10 cycles later; `aligned` rises after step 37 → `done`=1, `step_cnt`=37, exactly 37 `phase_en` pulses of 2 cycles each, `updn`=1, `cntsel`=0 throughout.
- Never aligned: `aligned` held 0 → `error`=1 after 144 steps, `step_cnt`=144, no 145th pulse.
- Lock loss: `locked` drops during step 20's WAIT_DONE_HI → `phase_en`=0, `step_cnt`=0, FSM waits. `locked` returns and `aligned` rises after 5 steps → `done`, `step_cnt`=5.
- Timeout (macro on, DONE_TIMEOUT=255): `phase_done` stuck high → `error`=1 exactly 255 cycles after entering WAIT_DONE_LO. Macro off: still `busy` after 10000 cycles.
- Reset mid-run at step 10: assert `rst_n`=0 → all outputs 0 asynchronously; a `start` pulse during the run is ignored; a `start` in DONE clears `done` and begins a new run.
